chan_mux_rr: RTL and testbench



---
 rtl/chan_mux_rr_if.sv | 27 ++
 rtl/chan_mux_rr.sv | 92 +++++++++
 tb/tb_chan_mux_rr.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/chan_mux_rr_if.sv
// rtl/chan_mux_rr_if.sv - channel-side and output-side handshake bundle for chan_mux_rr
interface chan_mux_rr_if #(
   parameter int WIDTH = 20,
   parameter int N     = 16
);
   localparam int SEL_W = $clog2(N);

   logic                 mode;
   logic [SEL_W-1:0]     select;
   logic [N-1:0]         in_valid;
   logic [N*WIDTH-1:0]   in_data;
   logic [N-1:0]         in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SEL_W-1:0]     out_chan;
   logic                 out_ready;

   modport slave (
      input  mode, select, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_chan
   );

   modport master (
      output mode, select, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_chan
   );
endinterface

// File: rtl/chan_mux_rr.sv
// rtl/chan_mux_rr.sv - N-channel registered mux with direct select or round-robin arbitration
module chan_mux_rr #(
   parameter int WIDTH = 20,
   parameter int N     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   chan_mux_rr_if.slave  bus
);
   localparam int SEL_W = $clog2(N);

   logic [SEL_W-1:0] ptr;
   logic [WIDTH-1:0] chan_data [N];
   logic             load_en;
   logic             direct_ok;
   logic             rr_found;
   logic [SEL_W-1:0] rr_g;
   logic [SEL_W:0]   idx;
   logic             grant;
   logic [SEL_W-1:0] g;
   logic             transfer;

   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign chan_data[k] = bus.in_data[k*WIDTH +: WIDTH];
   end

   // Output register can take a word when empty or being drained this cycle.
   assign load_en = !bus.out_valid || bus.out_ready;

   // Select indices at or above N (non-power-of-two N) never grant.
   assign direct_ok = ({1'b0, bus.select} < (SEL_W+1)'(N)) && bus.in_valid[bus.select];

   // Round-robin scan: first valid channel starting at ptr, wrapping at N.
   always_comb begin
      rr_found = 1'b0;
      rr_g     = '0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + (SEL_W+1)'(i);
         if (idx >= (SEL_W+1)'(N)) begin
            idx = idx - (SEL_W+1)'(N);
         end
         if (!rr_found && bus.in_valid[idx[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_g     = idx[SEL_W-1:0];
         end
      end
   end

   // Pick the grant source according to the current mode.
   always_comb begin
      grant = 1'b0;
      g     = '0;
      if (bus.mode) begin
         grant = rr_found;
         g     = rr_g;
      end else begin
         grant = direct_ok;
         g     = bus.select;
      end
   end

   // Gating with rst_n keeps every in_ready low while reset is held.
   assign transfer     = rst_n && load_en && grant;
   assign bus.in_ready = transfer ? (N'(1) << g) : '0;

   // Output register: load on transfer, empty on idle load slot, hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_chan  <= '0;
      end else if (load_en) begin
         if (grant) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= chan_data[g];
            bus.out_chan  <= g;
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   // Round-robin pointer moves past the winner only on round-robin transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (transfer && bus.mode) begin
         ptr <= ({1'b0, g} == (SEL_W+1)'(N-1)) ? '0 : g + SEL_W'(1);
      end
   end
endmodule

// File: tb/tb_chan_mux_rr.sv
// tb/tb_chan_mux_rr.sv - table-driven and scoreboard checks for chan_mux_rr
module tb_chan_mux_rr;
   localparam int W   = 20;
   localparam int N   = 16;
   localparam int N12 = 12;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   chan_mux_rr_if #(.WIDTH(W), .N(N))   bus16 ();
   chan_mux_rr_if #(.WIDTH(W), .N(N12)) bus12 ();

   chan_mux_rr #(.WIDTH(W), .N(N))   dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   chan_mux_rr #(.WIDTH(W), .N(N12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

   typedef struct packed {
      logic         mode;
      logic [3:0]   sel;
      logic [15:0]  valid;
      logic [W-1:0] seed;
      logic         rdy;
      logic [15:0]  exp_ready;
      logic         exp_ov;
   } vec_t;

   typedef struct packed {
      logic [4:0]   chan;
      logic [W-1:0] data;
   } word_t;

   vec_t  vt[$];
   word_t sb[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic m, input logic [3:0] s, input logic [15:0] v,
                               input logic [W-1:0] sd, input logic r,
                               input logic [15:0] er, input logic eov);
      vec_t x;
      x.mode = m; x.sel = s; x.valid = v; x.seed = sd; x.rdy = r;
      x.exp_ready = er; x.exp_ov = eov;
      return x;
   endfunction

   task automatic drive16(input logic m, input logic [3:0] s, input logic [15:0] v,
                          input logic [W-1:0] sd, input logic r);
      bus16.mode      = m;
      bus16.select    = s;
      bus16.in_valid  = v;
      bus16.out_ready = r;
      for (int k = 0; k < N; k++) bus16.in_data[k*W +: W] = sd + W'(k);
   endtask

   task automatic drive12(input logic [3:0] s, input logic [11:0] v,
                          input logic [W-1:0] sd, input logic r);
      bus12.mode      = 1'b0;
      bus12.select    = s;
      bus12.in_valid  = v;
      bus12.out_ready = r;
      for (int k = 0; k < N12; k++) bus12.in_data[k*W +: W] = sd + W'(k);
   endtask

   initial begin
      vec_t  v;
      word_t w;
      int    ch;

      // Stimulus table for the 16-channel instance.
      vt.push_back(mk(1'b0, 4'd5, 16'h0020, 20'hABCD9, 1'b1, 16'h0020, 1'b1));
      vt.push_back(mk(1'b0, 4'd6, 16'h0020, 20'hABCD9, 1'b1, 16'h0000, 1'b0));
      for (int k = 0; k < 19; k++)
         vt.push_back(mk(1'b1, 4'd0, 16'hFFFF, '0, 1'b1, 16'(1) << (k % 16), 1'b1));
      vt.push_back(mk(1'b1, 4'd0, 16'h8004, '0, 1'b1, 16'h8000, 1'b1));
      vt.push_back(mk(1'b1, 4'd0, 16'h8004, '0, 1'b1, 16'h0004, 1'b1));
      vt.push_back(mk(1'b1, 4'd0, 16'h8004, '0, 1'b1, 16'h8000, 1'b1));
      for (int k = 0; k < 3; k++)
         vt.push_back(mk(1'b1, 4'd0, 16'hFFFF, '0, 1'b0, 16'h0000, 1'b1));
      for (int k = 0; k < 5; k++)
         vt.push_back(mk(1'b1, 4'd0, 16'hFFFF, '0, 1'b1, 16'(1) << k, 1'b1));
      vt.push_back(mk(1'b0, 4'd9, 16'hFFFF, '0, 1'b1, 16'h0200, 1'b1));
      vt.push_back(mk(1'b0, 4'd9, 16'hFFFF, '0, 1'b1, 16'h0200, 1'b1));
      vt.push_back(mk(1'b1, 4'd9, 16'hFFFF, '0, 1'b1, 16'h0020, 1'b1));
      vt.push_back(mk(1'b1, 4'd0, 16'h0000, '0, 1'b1, 16'h0000, 1'b0));

      // Reset with round-robin traffic offered: nothing may be accepted.
      rst_n = 1'b0;
      drive16(1'b1, 4'd0, 16'hFFFF, '0, 1'b1);
      drive12(4'd0, 12'h000, '0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", bus16.out_valid, 1'b0);
      check("rst_out_data", bus16.out_data, '0);
      check("rst_out_chan", bus16.out_chan, '0);
      check("rst_in_ready", bus16.in_ready, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_first_grant", bus16.in_ready, 16'h0001);
      @(negedge clk);
      check("stream_chan0", bus16.out_chan, 4'd0);
      @(negedge clk);
      check("stream_chan1_valid", bus16.out_valid, 1'b1);
      check("stream_chan1_data", bus16.out_data, 20'd1);

      // Reset mid-stream with a held word.
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus16.out_valid, 1'b0);
      check("midrst_out_data", bus16.out_data, '0);
      check("midrst_out_chan", bus16.out_chan, '0);
      check("midrst_in_ready", bus16.in_ready, 16'h0000);
      @(posedge clk);
      #1;
      check("midrst_in_ready_held", bus16.in_ready, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_ptr_cleared", bus16.in_ready, 16'h0001);
      bus16.in_valid = 16'h0000;
      @(negedge clk);
      check("idle_out_valid", bus16.out_valid, 1'b0);

      // Table-driven run with scoreboard of accepted words.
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         drive16(v.mode, v.sel, v.valid, v.seed, v.rdy);
         #1;
         check($sformatf("in_ready[%0d]", i), bus16.in_ready, v.exp_ready);
         if (bus16.out_valid && v.rdy) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow[%0d]: got drain of chan %0d, required no word", i, bus16.out_chan);
            end else begin
               w = sb.pop_front();
               check($sformatf("out_chan[%0d]", i), bus16.out_chan, w.chan);
               check($sformatf("out_data[%0d]", i), bus16.out_data, w.data);
            end
         end
         if (v.exp_ready != 16'h0000) begin
            ch = 0;
            for (int j = 0; j < N; j++) if (v.exp_ready[j]) ch = j;
            w.chan = 5'(ch);
            w.data = v.seed + W'(ch);
            sb.push_back(w);
         end
         @(negedge clk);
         check($sformatf("out_valid[%0d]", i), bus16.out_valid, v.exp_ov);
         if (!v.rdy && sb.size() != 0) begin
            check($sformatf("frozen_chan[%0d]", i), bus16.out_chan, sb[0].chan);
            check($sformatf("frozen_data[%0d]", i), bus16.out_data, sb[0].data);
         end
      end
      check("sb_empty", 64'(sb.size()), 64'd0);

      // Twelve-channel instance: out-of-range select, then the top channel.
      drive12(4'd13, 12'hFFF, 20'h12340, 1'b1);
      #1;
      check("n12_sel13_in_ready", bus12.in_ready, 12'h000);
      @(negedge clk);
      check("n12_sel13_out_valid", bus12.out_valid, 1'b0);
      drive12(4'd11, 12'hFFF, 20'h12340, 1'b1);
      #1;
      check("n12_sel11_in_ready", bus12.in_ready, 12'h800);
      @(negedge clk);
      check("n12_sel11_out_valid", bus12.out_valid, 1'b1);
      check("n12_sel11_out_chan", bus12.out_chan, 4'd11);
      check("n12_sel11_out_data", bus12.out_data, 20'h1234B);
      drive12(4'd0, 12'h000, '0, 1'b1);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
